// File: rtl/ip_v4_pkg.sv
// Shared IPv4 header definitions: field positions, constants, checker FSM
// states and the 16-bit one's-complement fold used by checker and generator.
package ip_v4_pkg;

  localparam logic [3:0] IPV4_VERSION = 4'd4;
  localparam int         MIN_IHL_DEF  = 5;

  // Bit positions of the fields carried in header word 0.
  localparam int VER_MSB  = 31;
  localparam int VER_LSB  = 28;
  localparam int IHL_MSB  = 27;
  localparam int IHL_LSB  = 24;
  localparam int TLEN_MSB = 15;
  localparam int TLEN_LSB = 0;

  // 15 words * 2 half-words * 0xFFFF stays below 2^21, so no wrap.
  localparam int ACC_W = 21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    DRAIN = 2'd2
  } hc_state_e;

  // Two end-around-carry folds of the wide accumulator down to 16 bits.
  // After the first fold the carry is at most 1 and the low half is small
  // whenever it is set, so the second fold cannot overflow.
  function automatic logic [15:0] ones_comp_fold(input logic [ACC_W-1:0] acc);
    logic [16:0] s;
    s = {1'b0, acc[15:0]} + {12'd0, acc[ACC_W-1:16]};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ones_comp_acc.sv
// One's-complement accumulator: clears, adds both half-words of a 32-bit
// word, and presents the folded value including this cycle's addition.
module ones_comp_acc
  import ip_v4_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        add,
  input  logic [31:0] din,
  output logic [15:0] sum_nxt
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // Next accumulator value: clear wins over add.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = acc_q + {5'd0, din[31:16]} + {5'd0, din[15:0]};
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Folding the next value lets the verdict include the final word.
  assign sum_nxt = ones_comp_fold(acc_d);

endmodule

// File: rtl/ip_v4_header_check.sv
// IPv4 receive header checker. After start, parses word 0, sums IHL header
// words and issues a registered single-cycle verdict with format flags.
//
// Handshake: a word is accepted on a clk edge where the FSM is in HDR,
// d_in_vld=1 and start=0. start always wins and drops same-cycle data.
// hdr_vld pulses one cycle after the edge accepting the last header word;
// the verdict fields hold until the next verdict or reset.
module ip_v4_header_check
  import ip_v4_pkg::*;
#(
  parameter bit CHECK_VERSION = 1'b1,
  parameter int MIN_IHL       = MIN_IHL_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] d_in,
  input  logic        d_in_vld,
  output logic        hdr_vld,
  output logic        hdr_ok,
  output logic        ver_err,
  output logic        ihl_err,
  output logic        len_err,
  output logic [3:0]  ihl,
  output logic [15:0] sum_res,
  output logic [1:0]  dbg_state
);

  hc_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  ver_q, ver_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [15:0] tlen_q, tlen_d;

  logic        hdr_vld_q, hdr_vld_d;
  logic        hdr_ok_q, hdr_ok_d;
  logic        ver_err_q, ver_err_d;
  logic        ihl_err_q, ihl_err_d;
  logic        len_err_q, len_err_d;
  logic [3:0]  ihl_res_q, ihl_res_d;
  logic [15:0] sum_res_q, sum_res_d;

  logic        acc_clr, acc_add;
  logic [15:0] sum_nxt;

  logic [3:0]  cur_ver, cur_ihl;
  logic [15:0] cur_tlen;
  logic        e_ver, e_ihl, e_len, last_word;

  ones_comp_acc u_acc (
    .clk     (clk),
    .reset   (reset),
    .clr     (acc_clr),
    .add     (acc_add),
    .din     (d_in),
    .sum_nxt (sum_nxt)
  );

  // Field values in force for this word: live from d_in on word 0, latched after.
  always_comb begin
    cur_ver   = ver_q;
    cur_ihl   = ihl_q;
    cur_tlen  = tlen_q;
    if (cnt_q == 4'd0) begin
      cur_ver  = d_in[VER_MSB:VER_LSB];
      cur_ihl  = d_in[IHL_MSB:IHL_LSB];
      cur_tlen = d_in[TLEN_MSB:TLEN_LSB];
    end
    e_ver     = CHECK_VERSION && (cur_ver != IPV4_VERSION);
    e_ihl     = ({28'd0, cur_ihl} < 32'(MIN_IHL));
    e_len     = (cur_tlen < {10'd0, cur_ihl, 2'b00}) && !e_ihl;
    last_word = (cnt_q == 4'd0) ? e_ihl : (cnt_q == (ihl_q - 4'd1));
  end

  // Next-state, word counting and verdict generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ver_d     = ver_q;
    ihl_d     = ihl_q;
    tlen_d    = tlen_q;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    hdr_vld_d = 1'b0;
    hdr_ok_d  = hdr_ok_q;
    ver_err_d = ver_err_q;
    ihl_err_d = ihl_err_q;
    len_err_d = len_err_q;
    ihl_res_d = ihl_res_q;
    sum_res_d = sum_res_q;

    if (start) begin
      // From any state, including an aborted header in HDR.
      state_d = HDR;
      cnt_d   = 4'd0;
      ver_d   = 4'd0;
      ihl_d   = 4'd0;
      tlen_d  = 16'd0;
      acc_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, DRAIN: begin
          state_d = state_q;
        end
        HDR: begin
          if (d_in_vld) begin
            acc_add = 1'b1;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd0) begin
              ver_d  = cur_ver;
              ihl_d  = cur_ihl;
              tlen_d = cur_tlen;
            end
            if (last_word) begin
              state_d   = DRAIN;
              hdr_vld_d = 1'b1;
              ver_err_d = e_ver;
              ihl_err_d = e_ihl;
              len_err_d = e_len;
              ihl_res_d = cur_ihl;
              sum_res_d = sum_nxt;
              hdr_ok_d  = (sum_nxt == 16'hFFFF) && !e_ver && !e_ihl && !e_len;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, parsed-field and verdict registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      ver_q     <= 4'd0;
      ihl_q     <= 4'd0;
      tlen_q    <= 16'd0;
      hdr_vld_q <= 1'b0;
      hdr_ok_q  <= 1'b0;
      ver_err_q <= 1'b0;
      ihl_err_q <= 1'b0;
      len_err_q <= 1'b0;
      ihl_res_q <= 4'd0;
      sum_res_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ver_q     <= ver_d;
      ihl_q     <= ihl_d;
      tlen_q    <= tlen_d;
      hdr_vld_q <= hdr_vld_d;
      hdr_ok_q  <= hdr_ok_d;
      ver_err_q <= ver_err_d;
      ihl_err_q <= ihl_err_d;
      len_err_q <= len_err_d;
      ihl_res_q <= ihl_res_d;
      sum_res_q <= sum_res_d;
    end
  end

  assign hdr_vld   = hdr_vld_q;
  assign hdr_ok    = hdr_ok_q;
  assign ver_err   = ver_err_q;
  assign ihl_err   = ihl_err_q;
  assign len_err   = len_err_q;
  assign ihl       = ihl_res_q;
  assign sum_res   = sum_res_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ip_v4_header_check.sv
// Bench for ip_v4_header_check: directed header table, abort/reset
// sequences and randomly generated headers with patched checksums.
module tb_ip_v4_header_check;

  typedef logic [31:0] hdr_t [16];

  typedef struct {
    hdr_t        w;
    int          n;      // words driven
    int          vword;  // index of word after which hdr_vld is due, -1 none
    int          gap;    // max random idle cycles before each word
    logic        ok;
    logic        ver;
    logic        ihle;
    logic        lene;
    logic [3:0]  ihl;
    logic [15:0] sum;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] d_in;
  logic        d_in_vld;
  logic        hdr_vld;
  logic        hdr_ok;
  logic        ver_err;
  logic        ihl_err;
  logic        len_err;
  logic [3:0]  ihl;
  logic [15:0] sum_res;
  logic [1:0]  dbg_state;

  int n_chk;
  int n_fail;

  ip_v4_header_check dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .d_in      (d_in),
    .d_in_vld  (d_in_vld),
    .hdr_vld   (hdr_vld),
    .hdr_ok    (hdr_ok),
    .ver_err   (ver_err),
    .ihl_err   (ihl_err),
    .len_err   (len_err),
    .ihl       (ihl),
    .sum_res   (sum_res),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Independent reference: running end-around-carry sum of half-words.
  function automatic logic [15:0] oc_sum(input hdr_t w, input int n);
    logic [16:0] s;
    s = 17'd0;
    for (int i = 0; i < n; i++) begin
      s = s + {1'b0, w[i][31:16]};
      if (s[16]) s = s - 17'h0FFFF;
      s = s + {1'b0, w[i][15:0]};
      if (s[16]) s = s - 17'h0FFFF;
    end
    return s[15:0];
  endfunction

  function automatic hdr_t gold_hdr();
    hdr_t w;
    w    = '{default: 32'h0};
    w[0] = 32'h4500_0073;
    w[1] = 32'h0000_4000;
    w[2] = 32'h4011_B861;
    w[3] = 32'hC0A8_0001;
    w[4] = 32'hC0A8_00C7;
    return w;
  endfunction

  function automatic vec_t mk(input hdr_t w, input int n, input int vword, input int gap,
                              input logic ok, input logic ver, input logic ihle,
                              input logic lene, input logic [3:0] ih, input logic [15:0] sum);
    vec_t v;
    v.w = w; v.n = n; v.vword = vword; v.gap = gap;
    v.ok = ok; v.ver = ver; v.ihle = ihle; v.lene = lene; v.ihl = ih; v.sum = sum;
    return v;
  endfunction

  // Driver: start pulse carrying a stray valid word that must be dropped,
  // then the words with optional gaps; hdr_vld checked after every word.
  task automatic run_vec(input vec_t v);
    int g;
    start    = 1'b1;
    d_in_vld = 1'b1;
    d_in     = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start    = 1'b0;
    d_in_vld = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      g = (v.gap > 0) ? int'($urandom_range(v.gap, 0)) : 0;
      repeat (g) begin
        @(posedge clk); #1;
        chk("hdr_vld_gap", {31'd0, hdr_vld}, 32'd0);
      end
      d_in     = v.w[i];
      d_in_vld = 1'b1;
      @(posedge clk); #1;
      d_in_vld = 1'b0;
      chk("hdr_vld", {31'd0, hdr_vld}, {31'd0, (i == v.vword)});
      if (i == v.vword) begin
        chk("hdr_ok",  {31'd0, hdr_ok},  {31'd0, v.ok});
        chk("ver_err", {31'd0, ver_err}, {31'd0, v.ver});
        chk("ihl_err", {31'd0, ihl_err}, {31'd0, v.ihle});
        chk("len_err", {31'd0, len_err}, {31'd0, v.lene});
        chk("ihl",     {28'd0, ihl},     {28'd0, v.ihl});
        chk("sum_res", {16'd0, sum_res}, {16'd0, v.sum});
      end
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_hdr_vld"}, {31'd0, hdr_vld}, 32'd0);
    chk({tag, "_hdr_ok"},  {31'd0, hdr_ok},  32'd0);
    chk({tag, "_ver_err"}, {31'd0, ver_err}, 32'd0);
    chk({tag, "_ihl_err"}, {31'd0, ihl_err}, 32'd0);
    chk({tag, "_len_err"}, {31'd0, len_err}, 32'd0);
    chk({tag, "_ihl"},     {28'd0, ihl},     32'd0);
    chk({tag, "_sum_res"}, {16'd0, sum_res}, 32'd0);
    chk({tag, "_state"},   {30'd0, dbg_state}, 32'd0);
  endtask

  vec_t vecs[6];
  hdr_t w;
  vec_t r;
  int   ih;
  int   j;
  logic [15:0] s;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    d_in     = 32'h0;
    d_in_vld = 1'b0;

    // Hand-computed directed table.
    w = gold_hdr();
    w[5] = 32'hDEAD_BEEF; w[6] = 32'h0123_4567; w[7] = 32'hFFFF_FFFF;
    vecs[0] = mk(w, 8, 4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 16'hFFFF);
    w = gold_hdr(); w[2] = 32'h4011_B862;
    // One more than a valid sum wraps end-around from 0xFFFF to 0x0001.
    vecs[1] = mk(w, 5, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 16'h0001);
    w = gold_hdr();
    w[0] = 32'h4600_0020; w[2] = 32'h4011_B6B3; w[5] = 32'h0101_0000;
    vecs[2] = mk(w, 6, 5, 9, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 16'hFFFF);
    w = gold_hdr(); w[0] = 32'h6500_0073;
    vecs[3] = mk(w, 5, 4, 0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 16'h2000);
    w = gold_hdr(); w[0] = 32'h4300_0073;
    vecs[4] = mk(w, 5, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 16'h4373);
    w = gold_hdr(); w[0] = 32'h4500_0010;
    vecs[5] = mk(w, 5, 4, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 16'hFF9C);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_zero_outputs("reset");

    // Valid data in IDLE without start is ignored.
    for (int i = 0; i < 4; i++) begin
      d_in = gold_hdr()[i]; d_in_vld = 1'b1;
      @(posedge clk); #1;
      chk("idle_no_vld", {31'd0, hdr_vld}, 32'd0);
    end
    d_in_vld = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Verdict fields hold while hdr_vld stays low.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_vld", {31'd0, hdr_vld}, 32'd0);
    chk("hold_len_err", {31'd0, len_err}, 32'd1);
    chk("hold_sum", {16'd0, sum_res}, 32'h0000_FF9C);

    // Abort after word 2, then a full gold header: exactly one verdict.
    r = mk(gold_hdr(), 3, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    run_vec(r);
    r = mk(gold_hdr(), 5, 4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 16'hFFFF);
    run_vec(r);
    @(posedge clk); #1;
    chk("abort_single_pulse", {31'd0, hdr_vld}, 32'd0);

    // Reset after word 3: no verdict, outputs cleared, IDLE again.
    r = mk(gold_hdr(), 4, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    run_vec(r);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_zero_outputs("midreset");
    d_in = gold_hdr()[4]; d_in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midreset_no_vld", {31'd0, hdr_vld}, 32'd0);
    end
    d_in_vld = 1'b0;

    // Random headers, back-to-back; odd iterations carry one flipped bit.
    for (int k = 0; k < 2000; k++) begin
      ih   = int'($urandom_range(15, 5));
      w    = '{default: 32'h0};
      w[0] = {4'h4, 4'(ih), 8'($urandom), 16'($urandom_range(65535, ih * 4))};
      for (int i = 1; i < ih; i++) w[i] = $urandom;
      w[2][15:0] = 16'h0000;
      w[2][15:0] = ~oc_sum(w, ih);
      if (k % 2 == 1) begin
        j = int'($urandom_range(ih - 1, 1));
        w[j] = w[j] ^ (32'd1 << $urandom_range(31, 0));
      end
      s = oc_sum(w, ih);
      if (k % 2 == 0) chk("rand_model_good", {16'd0, s}, 32'h0000_FFFF);
      r = mk(w, ih, ih - 1, (k % 4 == 3) ? 2 : 0, (k % 2 == 0), 1'b0, 1'b0, 1'b0,
             4'(ih), s);
      run_vec(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
